core_data_periph_demux: RTL and testbench

Parametrised one-master-to-N-slave demultiplexer for the cluster peripheral interconnect. It takes one core data request port and routes it to NB_SLAVES peripheral slave ports by address, with an internal error slave for unmapped indices. It tracks outstanding transactions so responses return in order. It generalises the fixed-width, fixed-count core data request/response pairing to arbitrary widths, slave counts and outstanding depth. It sits between a core's data port and the peripheral slave plugs (EOC, timer, event unit, HWPE, icache ctrl, DMA, HMR, ext).

---
 rtl/core_data_periph_demux_pkg.sv | 46 ++++
 rtl/core_data_periph_demux_err_slave.sv | 35 +++
 rtl/core_data_periph_demux.sv | 161 ++++++++++++++++
 tb/tb_core_data_periph_demux.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_data_periph_demux_pkg.sv
// core_data_periph_demux_pkg
// Shared types and constants for the core data peripheral demultiplexer.
//   - legacy fixed-width (32-bit) core data request/response structs
//   - peripheral slave index map (ERROR index is NB_SLAVES of the instance)
//   - default error slave read data
package core_data_periph_demux_pkg;

  localparam int unsigned CORE_AW = 32;
  localparam int unsigned CORE_DW = 32;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

  // Slave index map of the cluster peripheral interconnect.
  localparam int unsigned SLV_EOC         = 0;
  localparam int unsigned SLV_TIMER       = 1;
  localparam int unsigned SLV_EVENT       = 2;
  localparam int unsigned SLV_HWPE        = 3;
  localparam int unsigned SLV_ICACHE_CTRL = 4;
  localparam int unsigned SLV_DMA         = 5;
  localparam int unsigned SLV_HMR         = 6;
  localparam int unsigned SLV_RSVD_7      = 7;
  localparam int unsigned SLV_RSVD_8      = 8;
  localparam int unsigned SLV_EXT         = 9;
  localparam int unsigned NB_SLAVES_DEFAULT = 10;

  typedef struct packed {
    logic                 req;
    logic [CORE_AW-1:0]   add;
    logic                 wen;
    logic [CORE_DW-1:0]   data;
    logic [CORE_DW/8-1:0] be;
  } core_data_req_t;

  typedef struct packed {
    logic               gnt;
    logic               r_valid;
    logic               r_opc;
    logic [CORE_DW-1:0] r_data;
  } core_data_rsp_t;

  // The error slave always sits one past the last real slave.
  function automatic int unsigned err_slave_idx(input int unsigned nb_slaves);
    return nb_slaves;
  endfunction

endpackage

// File: rtl/core_data_periph_demux_err_slave.sv
// periph_err_slave
// Single-cycle error responder for unmapped slave indices. Always grants;
// every granted request returns r_valid=1, r_data=ERR_DATA, r_opc=1 one
// cycle later. Back-to-back requests give back-to-back responses.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i / gnt_o        request handshake (gnt_o = req_i)
//   r_valid_o, r_data_o, r_opc_o   response
module periph_err_slave #(
  parameter int unsigned     DW       = 32,
  parameter logic [DW-1:0]   ERR_DATA = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  output logic          r_valid_o,
  output logic [DW-1:0] r_data_o,
  output logic          r_opc_o
);

  logic pend_q;

  assign gnt_o = req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= 1'b0;
    else       pend_q <= req_i;
  end

  assign r_valid_o = pend_q;
  assign r_data_o  = pend_q ? ERR_DATA : '0;
  assign r_opc_o   = pend_q;

endmodule

// File: rtl/core_data_periph_demux.sv
// core_data_periph_demux
// Routes one core data request port to NB_SLAVES peripheral slaves by the
// address index field m_add_i[IDX_LSB +: IDX_W]; indices >= NB_SLAVES go to
// an internal error slave. Outstanding requests are limited to one target at
// a time so responses always return in issue order.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   m_req_i, m_add_i, m_wen_i, m_data_i, m_be_i, m_gnt_o   master request
//   m_r_valid_o, m_r_data_o, m_r_opc_o   master response (opc=1 error)
//   s_req_o, s_gnt_i                     per-slave request/grant
//   s_add_o, s_wen_o, s_data_o, s_be_o   broadcast request payload
//   s_r_valid_i, s_r_data_i, s_r_opc_i   per-slave responses
//   busy_o                               requests are outstanding
module core_data_periph_demux
  import core_data_periph_demux_pkg::*;
#(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned NB_SLAVES       = 10,
  parameter int unsigned IDX_LSB         = 10,
  parameter int unsigned IDX_W           = $clog2(NB_SLAVES+1),
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           m_req_i,
  input  logic [AW-1:0]                  m_add_i,
  input  logic                           m_wen_i,
  input  logic [DW-1:0]                  m_data_i,
  input  logic [DW/8-1:0]                m_be_i,
  output logic                           m_gnt_o,
  output logic                           m_r_valid_o,
  output logic [DW-1:0]                  m_r_data_o,
  output logic                           m_r_opc_o,
  output logic [NB_SLAVES-1:0]           s_req_o,
  output logic [AW-1:0]                  s_add_o,
  output logic                           s_wen_o,
  output logic [DW-1:0]                  s_data_o,
  output logic [DW/8-1:0]                s_be_o,
  input  logic [NB_SLAVES-1:0]           s_gnt_i,
  input  logic [NB_SLAVES-1:0]           s_r_valid_i,
  input  logic [NB_SLAVES-1:0][DW-1:0]   s_r_data_i,
  input  logic [NB_SLAVES-1:0]           s_r_opc_i,
  output logic                           busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(err_slave_idx(NB_SLAVES));
  localparam logic [CW-1:0]    CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [DW-1:0]    ERR_DATA_DW = DW'(ERR_DATA);

  typedef struct packed {
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
  } req_payload_t;

  req_payload_t     payload;
  logic [IDX_W-1:0] idx_raw;
  logic [IDX_W-1:0] tgt;
  logic [IDX_W-1:0] tgt_q;
  logic [CW-1:0]    cnt_q;
  logic             allowed;
  logic             handshake;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_opc;

  logic             err_req;
  logic             err_gnt;
  logic             err_r_valid;
  logic [DW-1:0]    err_r_data;
  logic             err_r_opc;

  // Payload is broadcast; only the selected s_req_o qualifies it.
  assign payload  = '{add: m_add_i, wen: m_wen_i, data: m_data_i, be: m_be_i};
  assign s_add_o  = payload.add;
  assign s_wen_o  = payload.wen;
  assign s_data_o = payload.data;
  assign s_be_o   = payload.be;

  assign idx_raw = m_add_i[IDX_LSB +: IDX_W];
  assign tgt     = (idx_raw >= ERR_IDX) ? ERR_IDX : idx_raw;

  // Uses the registered count: a response in a full cycle or the last
  // response of a burst only opens the gate on the following cycle.
  assign allowed = (cnt_q < CNT_MAX) && ((cnt_q == '0) || (tgt == tgt_q));

  always_comb begin
    s_req_o = '0;
    err_req = 1'b0;
    m_gnt_o = 1'b0;
    if (allowed) begin
      if (tgt == ERR_IDX) begin
        err_req = m_req_i;
        m_gnt_o = err_gnt;
      end else begin
        s_req_o[tgt] = m_req_i;
        m_gnt_o      = s_gnt_i[tgt];
      end
    end
  end

  assign handshake = m_req_i & m_gnt_o;

  // Only the current target may answer, and only while something is in
  // flight; anything else is a stray response and is dropped.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_opc   = 1'b0;
    if (cnt_q != '0) begin
      if (tgt_q == ERR_IDX) begin
        rsp_valid = err_r_valid;
        rsp_data  = err_r_data;
        rsp_opc   = err_r_opc;
      end else if (s_r_valid_i[tgt_q]) begin
        rsp_valid = 1'b1;
        rsp_data  = s_r_data_i[tgt_q];
        rsp_opc   = s_r_opc_i[tgt_q];
      end
    end
  end

  assign m_r_valid_o = rsp_valid;
  assign m_r_data_o  = rsp_data;
  assign m_r_opc_o   = rsp_opc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      if (handshake) tgt_q <= tgt;
      // rsp_valid is already gated by cnt_q != 0, so no underflow here.
      case ({handshake, rsp_valid})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign busy_o = (cnt_q != '0);

  periph_err_slave #(
    .DW       (DW),
    .ERR_DATA (ERR_DATA_DW)
  ) i_err_slave (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (err_req),
    .gnt_o     (err_gnt),
    .r_valid_o (err_r_valid),
    .r_data_o  (err_r_data),
    .r_opc_o   (err_r_opc)
  );

endmodule

// File: tb/tb_core_data_periph_demux.sv
module tb_core_data_periph_demux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 10;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  m_req_i;
  logic [AW-1:0]         m_add_i;
  logic                  m_wen_i;
  logic [DW-1:0]         m_data_i;
  logic [DW/8-1:0]       m_be_i;
  logic                  m_gnt_o;
  logic                  m_r_valid_o;
  logic [DW-1:0]         m_r_data_o;
  logic                  m_r_opc_o;
  logic [NS-1:0]         s_req_o;
  logic [AW-1:0]         s_add_o;
  logic                  s_wen_o;
  logic [DW-1:0]         s_data_o;
  logic [DW/8-1:0]       s_be_o;
  logic [NS-1:0]         s_gnt_i;
  logic [NS-1:0]         s_r_valid_i;
  logic [NS-1:0][DW-1:0] s_r_data_i;
  logic [NS-1:0]         s_r_opc_i;
  logic                  busy_o;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];   // {r_data, r_opc}

  core_data_periph_demux dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
    .m_data_i(m_data_i), .m_be_i(m_be_i), .m_gnt_o(m_gnt_o),
    .m_r_valid_o(m_r_valid_o), .m_r_data_o(m_r_data_o), .m_r_opc_o(m_r_opc_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o),
    .s_data_o(s_data_o), .s_be_o(s_be_o), .s_gnt_i(s_gnt_i),
    .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_opc_i(s_r_opc_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Response scoreboard: every master response must match the oldest expected.
  always @(negedge clk_i) begin
    if (!rst_i && m_r_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got data=%h opc=%b, expected no response",
                 m_r_data_o, m_r_opc_o);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({m_r_data_o, m_r_opc_o} !== e) begin
          errors++;
          $display("FAIL rsp_data: got data=%h opc=%b, expected data=%h opc=%b",
                   m_r_data_o, m_r_opc_o, e[DW:1], e[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    m_req_i     = 1'b0;
    m_add_i     = '0;
    m_wen_i     = 1'b1;
    m_data_i    = '0;
    m_be_i      = '1;
    s_gnt_i     = '0;
    s_r_valid_i = '0;
    s_r_data_i  = '0;
    s_r_opc_i   = '0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'(idx) << 10;
  endfunction

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    cyc(); cyc();
    settle();
    checks++;
    if ({m_gnt_o, s_req_o, busy_o, m_r_valid_o, m_r_opc_o, m_r_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b req=%b busy=%b rv=%b opc=%b data=%h, expected all 0",
               m_gnt_o, s_req_o, busy_o, m_r_valid_o, m_r_opc_o, m_r_data_o);
    end
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    m_req_i = 1'b1; m_add_i = 32'h400; m_wen_i = 1'b1;
    m_data_i = 32'hCAFE0001; m_be_i = 4'hF;
    s_gnt_i = 10'b00_0000_0010;
    settle();
    checks++;
    if (m_gnt_o !== 1'b1 || s_req_o !== 10'b00_0000_0010 || s_add_o !== 32'h400 ||
        s_wen_o !== 1'b1 || s_data_o !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL single_req: gnt=%b req=%b add=%h wen=%b data=%h, expected 1 0000000010 00000400 1 cafe0001",
               m_gnt_o, s_req_o, s_add_o, s_wen_o, s_data_o);
    end
    exp_q.push_back({32'h1234, 1'b0});
    cyc();
    idle();
    settle();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL single_busy: busy=%b, expected 1", busy_o);
    end
    cyc();
    s_r_valid_i[1] = 1'b1; s_r_data_i[1] = 32'h1234;
    settle();
    checks++;
    if (m_r_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_rvalid: rv=%b, expected 1", m_r_valid_o);
    end
    cyc();
    idle();
    settle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL single_done: busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_full();
    m_req_i = 1'b1; m_add_i = addr_of(2); s_gnt_i[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (m_gnt_o !== 1'b1) begin
        errors++; $display("FAIL full_grant%0d: gnt=%b, expected 1", i, m_gnt_o);
      end
      exp_q.push_back({32'h200 + 32'(i), 1'b0});
      cyc();
    end
    settle();
    checks++;
    if (m_gnt_o !== 1'b0 || s_req_o !== '0 || dut.cnt_q !== 3'd4) begin
      errors++;
      $display("FAIL full_stall: gnt=%b req=%b cnt=%0d, expected 0 0 4", m_gnt_o, s_req_o, dut.cnt_q);
    end
    cyc();
    s_r_valid_i[2] = 1'b1; s_r_data_i[2] = 32'h200;
    settle();
    checks++;
    if (m_gnt_o !== 1'b0) begin
      errors++; $display("FAIL full_same_cycle: gnt=%b, expected 0", m_gnt_o);
    end
    cyc();
    s_r_valid_i = '0;
    settle();
    checks++;
    if (m_gnt_o !== 1'b1 || s_req_o !== 10'b00_0000_0100) begin
      errors++; $display("FAIL full_regrant: gnt=%b req=%b, expected 1 0000000100", m_gnt_o, s_req_o);
    end
    exp_q.push_back({32'h204, 1'b0});
    cyc();
    m_req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_r_valid_i[2] = 1'b1; s_r_data_i[2] = 32'h200 + 32'(i);
      cyc();
    end
    idle();
    settle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL full_drain: busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_switch();
    m_req_i = 1'b1; m_add_i = addr_of(2); s_gnt_i = 10'b00_0000_1100;
    exp_q.push_back({32'h2222, 1'b0});
    cyc();
    m_add_i = addr_of(3);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (m_gnt_o !== 1'b0 || s_req_o !== '0) begin
        errors++; $display("FAIL switch_stall%0d: gnt=%b req=%b, expected 0 0", i, m_gnt_o, s_req_o);
      end
      cyc();
    end
    s_r_valid_i[2] = 1'b1; s_r_data_i[2] = 32'h2222;
    settle();
    checks++;
    if (m_gnt_o !== 1'b0) begin
      errors++; $display("FAIL switch_rsp_cycle: gnt=%b, expected 0", m_gnt_o);
    end
    cyc();
    s_r_valid_i = '0;
    settle();
    checks++;
    if (m_gnt_o !== 1'b1 || s_req_o !== 10'b00_0000_1000) begin
      errors++; $display("FAIL switch_grant: gnt=%b req=%b, expected 1 0000001000", m_gnt_o, s_req_o);
    end
    exp_q.push_back({32'h3333, 1'b1});
    cyc();
    m_req_i = 1'b0;
    s_r_valid_i[3] = 1'b1; s_r_data_i[3] = 32'h3333; s_r_opc_i[3] = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_error();
    m_req_i = 1'b1; m_add_i = addr_of(12) | 32'h3C; m_wen_i = 1'b0;
    settle();
    checks++;
    if (m_gnt_o !== 1'b1 || s_req_o !== '0) begin
      errors++; $display("FAIL err_grant: gnt=%b req=%b, expected 1 0", m_gnt_o, s_req_o);
    end
    exp_q.push_back({32'hBADACCE5, 1'b1});
    cyc();
    m_req_i = 1'b0;
    settle();
    checks++;
    if (m_r_valid_o !== 1'b1 || m_r_data_o !== 32'hBADACCE5 || m_r_opc_o !== 1'b1) begin
      errors++;
      $display("FAIL err_rsp: rv=%b data=%h opc=%b, expected 1 badacce5 1", m_r_valid_o, m_r_data_o, m_r_opc_o);
    end
    cyc();
    // idx == NB_SLAVES boundary, back-to-back
    m_req_i = 1'b1; m_add_i = addr_of(10);
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (m_gnt_o !== 1'b1) begin
        errors++; $display("FAIL err_b2b_grant%0d: gnt=%b, expected 1", i, m_gnt_o);
      end
      exp_q.push_back({32'hBADACCE5, 1'b1});
      cyc();
    end
    m_req_i = 1'b0;
    cyc();
    settle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL err_drain: busy=%b, expected 0", busy_o);
    end
    idle();
    cyc();
  endtask

  task automatic test_back_to_back();
    m_req_i = 1'b1; m_add_i = addr_of(4); s_gnt_i[4] = 1'b1;
    exp_q.push_back({32'hA0, 1'b0}); cyc();
    exp_q.push_back({32'hA1, 1'b0}); cyc();
    s_r_valid_i[4] = 1'b1; s_r_data_i[4] = 32'hA0;
    settle();
    checks++;
    if (m_gnt_o !== 1'b1) begin
      errors++; $display("FAIL b2b_grant: gnt=%b, expected 1", m_gnt_o);
    end
    exp_q.push_back({32'hA2, 1'b0});
    cyc();
    m_req_i = 1'b0; s_r_valid_i = '0;
    s_r_valid_i[5] = 1'b1; s_r_data_i[5] = 32'hDEAD;
    settle();
    checks++;
    if (dut.cnt_q !== 3'd2 || m_r_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cnt_spurious: cnt=%0d rv=%b, expected 2 0", dut.cnt_q, m_r_valid_o);
    end
    cyc();
    s_r_valid_i = '0;
    s_r_valid_i[4] = 1'b1; s_r_data_i[4] = 32'hA1; cyc();
    s_r_data_i[4] = 32'hA2; cyc();
    idle();
    settle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    m_req_i = 1'b1; m_add_i = addr_of(6); s_gnt_i[6] = 1'b1;
    cyc(); cyc(); cyc();
    m_req_i = 1'b0;
    settle();
    checks++;
    if (dut.cnt_q !== 3'd3 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: cnt=%0d busy=%b, expected 3 1", dut.cnt_q, busy_o);
    end
    rst_i = 1'b1;
    cyc();
    settle();
    checks++;
    if (dut.cnt_q !== 3'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: cnt=%0d busy=%b, expected 0 0", dut.cnt_q, busy_o);
    end
    rst_i = 1'b0;
    s_r_valid_i[6] = 1'b1; s_r_data_i[6] = 32'h6666;
    settle();
    checks++;
    if (m_r_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_late_rsp: rv=%b, expected 0", m_r_valid_o);
    end
    cyc();
    idle();
    rst_i = 1'b1; m_req_i = 1'b1; m_add_i = addr_of(12);
    cyc();
    rst_i = 1'b0; m_req_i = 1'b0;
    settle();
    checks++;
    if (m_r_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_err_cancel: rv=%b busy=%b, expected 0 0", m_r_valid_o, busy_o);
    end
    cyc();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    @(posedge clk_i); #1;
    test_reset();
    test_single_read();
    test_full();
    test_switch();
    test_error();
    test_back_to_back();
    test_reset_mid();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rsp_missing: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
